mem_test_seq: RTL and testbench
===============================

MEM_TEST_SEQ -- requirements
Module: mem_test_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters, one per line:
- START_ADDR, 24'h000000, first PSRAM address tested.
- NUM_WORDS, 256, number of byte locations tested (1..2^24).
- SETTLE_CYCLES, 5550000, power-up wait before the first access.
- TIMEOUT_CYCLES, 4096, maximum wait per access.
- SEED, 8'hA5, pattern XOR constant.
REQ-003 Ports, one per line:
- clk  in  1  system clock, drives the memory controller.
- reset  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start pulse, accepted in IDLE or DONE.
- i_busy  in  1  memory controller busy.
- i_dataReady  in  1  memory controller read data valid.
- i_dataRead  in  8  memory controller read data.
- o_cs  out  1  active-low request strobe to the memory controller.
- o_write  out  1  1=write, 0=read; valid while o_cs=0.
- o_address  out  24  request address.
- o_bank  out  1  PSRAM bank, always 0.
- o_dataToWrite  out  8  write data.
- o_done  out  1  test finished, level.
- o_pass  out  1  finished with zero errors and no timeout.
- o_timeout  out  1  test aborted on a timeout.
- o_errCount  out  16  mismatch count, saturating at 16'hFFFF.
- o_firstFailAddr  out  24  address of the first mismatch.
- o_led  out  1  1 when o_done=1 and o_pass=1.

Function
REQ-004 States SHALL be IDLE, SETTLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
REQ-005 Transitions:
- i_start in IDLE or DONE: go to SETTLE, clear o_done, o_pass, o_timeout, o_errCount and o_firstFailAddr, and load the settle counter with SETTLE_CYCLES.
- SETTLE: decrement each cycle; on reaching 0, go to WR_REQ with the index at 0.
REQ-006 Pattern for index i: address = START_ADDR + i, modulo 2^24 (wraps). Data = address[7:0] XOR SEED.
REQ-007 Write pass, WR_REQ:
- When i_busy=0, drive o_cs=0 for exactly one cycle with o_write=1, the address and the data, then go to WR_WAIT.
- While i_busy=1, hold with o_cs=1.
REQ-008 WR_WAIT SHALL ignore i_busy on its first cycle. After that, on i_busy=0 it SHALL advance:
- index < NUM_WORDS-1: increment the index and go to WR_REQ.
- otherwise: reset the index to 0 and go to RD_REQ.
REQ-009 Read pass: RD_REQ SHALL issue as in REQ-007 but with o_write=0.
REQ-010 RD_WAIT SHALL sample i_dataRead in the cycle where i_dataReady=1 and i_busy=0, then compare it with the expected pattern.
- On mismatch, increment o_errCount (saturating); on the first mismatch also load o_firstFailAddr.
- Then advance as in REQ-008; after the last index, go to DONE.
REQ-011 In DONE, o_done=1 and o_pass = (o_errCount==0 and o_timeout==0). The block stays in DONE until the next i_start.
REQ-012 Timeout: a counter SHALL load TIMEOUT_CYCLES on each request. If WR_WAIT or RD_WAIT lasts longer, set o_timeout=1 and go to DONE.
REQ-013 o_cs SHALL be 1 in every state and cycle except the single issue cycle.
REQ-014 i_start while busy (SETTLE through RD_WAIT) SHALL be ignored.
REQ-015 An i_dataReady pulse that arrives in WR_WAIT SHALL not be counted as a read result.

Reset
REQ-016 While reset=0, the block SHALL enter IDLE immediately and set outputs as follows:
- o_cs=1; all other outputs 0.
- o_address and o_firstFailAddr = 0; counters cleared.
REQ-017 Reset in the middle of an access SHALL abandon it with no further strobe. After reset, the block SHALL wait for a new i_start.

Structure
REQ-018 The state enum and the SEED/TIMEOUT defaults SHALL live in the shared memCtrl package header, so the top level and benches share them.
REQ-019 The down-counter used for settle and timeout SHALL be one sub-module, cycle_counter: load, enable and zero flag.
REQ-020 The block SHALL replace the ad-hoc test state machine in the top level. The top level SHALL drive i_start from the synchronised reset release and drive the LED from o_led.

Verification
REQ-021 Each bench scenario SHALL check the listed response:
- Ideal model (busy 2 cycles, 4-cycle read latency), NUM_WORDS=4, SETTLE_CYCLES=3: 4 writes then 4 reads. Writes are to 0..3 with data A5,A4,A7,A6. Result o_done=1, o_pass=1, o_errCount=0.
- Model corrupts address 2 (returns 8'h00): o_errCount=1, o_firstFailAddr=2, o_pass=0.
- START_ADDR=24'hFFFFFE, NUM_WORDS=4: addresses FFFFFE, FFFFFF, 000000, 000001 in both passes.
- Model holds i_busy=1 after the third write, TIMEOUT_CYCLES=16: o_timeout=1, o_done=1, o_pass=0 at most 17 cycles after the request.
- reset=0 during RD_WAIT: same cycle o_cs=1 and o_done=0. After release, state stays IDLE and no strobe occurs until i_start.
- i_start pulsed during WR_WAIT: no restart and the sequence completes. i_start in DONE: all results cleared and the test reruns.

Source files
------------

// File: rtl/mem_test_seq_pkg.sv
// mem_test_seq_pkg: shared state encoding, defaults and pattern helper for the PSRAM self-test
package mem_test_seq_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_e;
  localparam logic [7:0] DEF_SEED = 8'hA5;
  localparam int DEF_TIMEOUT = 4096;
  localparam int CNT_W = 32;
  function automatic logic [7:0] pattern(input logic [7:0] addr_lsb, input logic [7:0] seed);
    return addr_lsb ^ seed;
  endfunction
endpackage

// File: rtl/mem_test_seq_cycle_counter.sv
// cycle_counter: loadable down-counter; o_zero also flags the decrement that lands on zero this cycle
module cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = i_load ? i_val : (i_en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    o_zero = cnt_q == '0 || (i_en && cnt_q == W'(1));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_test_seq.sv
// mem_test_seq: PSRAM write-then-read-back self-test sequencer driving a memory controller
module mem_test_seq
  import mem_test_seq_pkg::*;
#(
  parameter logic [23:0] START_ADDR     = 24'h000000,
  parameter int          NUM_WORDS      = 256,
  parameter int          SETTLE_CYCLES  = 5550000,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter logic [7:0]  SEED           = DEF_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_busy,
  input  logic        i_dataReady,
  input  logic [7:0]  i_dataRead,
  output logic        o_cs,
  output logic        o_write,
  output logic [23:0] o_address,
  output logic        o_bank,
  output logic [7:0]  o_dataToWrite,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_errCount,
  output logic [23:0] o_firstFailAddr,
  output logic        o_led
);
  state_e state_q, state_d;
  logic [23:0] idx_q, idx_d, addr_q, addr_d, fail_q, fail_d;
  logic [15:0] err_q, err_d;
  logic first_q, first_d, tmo_q, tmo_d;
  logic issue, wait_ok, last, mism;
  logic cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  // one counter serves both the power-up settle and the per-access timeout
  cycle_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .reset(reset), .i_load(cnt_load), .i_val(cnt_val), .i_en(cnt_en), .o_zero(cnt_zero)
  );

  always_comb begin
    issue = (state_q == WR_REQ || state_q == RD_REQ) && !i_busy;
    wait_ok = !first_q && !i_busy;
    last = idx_q == 24'(NUM_WORDS - 1);
    mism = i_dataRead != pattern(addr_q[7:0], SEED);
    state_d = state_q;
    idx_d = idx_q;
    addr_d = addr_q;
    first_d = 1'b0;
    err_d = err_q;
    fail_d = fail_q;
    tmo_d = tmo_q;
    cnt_load = issue;
    cnt_val = CNT_W'(TIMEOUT_CYCLES);
    cnt_en = 1'b0;
    case (state_q)
      IDLE, DONE: if (i_start) begin
        state_d = SETTLE;
        err_d = '0;
        fail_d = '0;
        tmo_d = 1'b0;
        cnt_load = 1'b1;
        cnt_val = CNT_W'(SETTLE_CYCLES);
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d = WR_REQ;
          idx_d = '0;
          addr_d = START_ADDR;
        end
      end
      WR_REQ: if (issue) begin
        state_d = WR_WAIT;
        first_d = 1'b1;
      end
      RD_REQ: if (issue) begin
        state_d = RD_WAIT;
        first_d = 1'b1;
      end
      WR_WAIT: begin
        cnt_en = 1'b1;
        if (wait_ok) begin
          idx_d = last ? '0 : idx_q + 1'b1;
          addr_d = last ? START_ADDR : addr_q + 1'b1;
          state_d = last ? RD_REQ : WR_REQ;
        end else if (cnt_zero) begin
          tmo_d = 1'b1;
          state_d = DONE;
        end
      end
      RD_WAIT: begin
        cnt_en = 1'b1;
        if (wait_ok && i_dataReady) begin
          err_d = (mism && err_q != '1) ? err_q + 1'b1 : err_q;
          fail_d = (mism && err_q == '0) ? addr_q : fail_q;
          idx_d = last ? '0 : idx_q + 1'b1;
          addr_d = addr_q + 1'b1;
          state_d = last ? DONE : RD_REQ;
        end else if (cnt_zero) begin
          tmo_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      addr_q <= '0;
      fail_q <= '0;
      err_q <= '0;
      first_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      fail_q <= fail_d;
      err_q <= err_d;
      first_q <= first_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_cs = !issue;
  assign o_write = state_q == WR_REQ || state_q == WR_WAIT;
  assign o_address = addr_q;
  assign o_bank = 1'b0;
  assign o_dataToWrite = o_write ? pattern(addr_q[7:0], SEED) : 8'h00;
  assign o_done = state_q == DONE;
  assign o_pass = o_done && err_q == '0 && !tmo_q;
  assign o_timeout = tmo_q;
  assign o_errCount = err_q;
  assign o_firstFailAddr = fail_q;
  assign o_led = o_pass;
endmodule

// File: tb/tb_mem_test_seq.sv
// tb_mem_test_seq: randomized bench with a transaction-level PSRAM controller model and scoreboard
module tb_mem_test_seq;
  localparam int N = 4;
  typedef struct packed {logic w; logic [23:0] a; logic [7:0] d;} req_t;

  logic clk = 0, reset = 1, start_a = 0, start_b = 0, busy = 0, rdy = 0, sel = 0;
  logic [7:0] rdata = 0;
  logic cs_a, wr_a, bank_a, done_a, pass_a, tmo_a, led_a, cs_b, wr_b, bank_b, done_b, pass_b, tmo_b, led_b;
  logic [23:0] addr_a, ffa_a, addr_b, ffa_b;
  logic [7:0] wd_a, wd_b;
  logic [15:0] err_a, err_b;
  logic cs_m, wr_m, done_m, pass_m, tmo_m, led_m, bank_m;
  logic [23:0] addr_m, ffa_m;
  logic [7:0] wd_m;
  logic [15:0] err_m;
  assign {cs_m, wr_m, done_m, pass_m, tmo_m, led_m, bank_m, addr_m, ffa_m, wd_m, err_m} = sel ?
    {cs_b, wr_b, done_b, pass_b, tmo_b, led_b, bank_b, addr_b, ffa_b, wd_b, err_b} :
    {cs_a, wr_a, done_a, pass_a, tmo_a, led_a, bank_a, addr_a, ffa_a, wd_a, err_a};

  mem_test_seq #(.START_ADDR(24'h000000), .NUM_WORDS(N), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16), .SEED(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_busy(busy), .i_dataReady(rdy), .i_dataRead(rdata),
    .o_cs(cs_a), .o_write(wr_a), .o_address(addr_a), .o_bank(bank_a), .o_dataToWrite(wd_a), .o_done(done_a),
    .o_pass(pass_a), .o_timeout(tmo_a), .o_errCount(err_a), .o_firstFailAddr(ffa_a), .o_led(led_a));
  mem_test_seq #(.START_ADDR(24'hFFFFFE), .NUM_WORDS(N), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16), .SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_busy(busy), .i_dataReady(rdy), .i_dataRead(rdata),
    .o_cs(cs_b), .o_write(wr_b), .o_address(addr_b), .o_bank(bank_b), .o_dataToWrite(wd_b), .o_done(done_b),
    .o_pass(pass_b), .o_timeout(tmo_b), .o_errCount(err_b), .o_firstFailAddr(ffa_b), .o_led(led_b));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // controller model: one request per low strobe, busy for lat cycles, then read data with ready
  req_t log_q[$];
  logic [7:0] mem [logic [23:0]];
  bit bad [logic [23:0]];
  logic [7:0] cmask = 0, pend_data = 0;
  int pend = 0, wr_lat = 0, rd_lat = 0, wr_cnt = 0, req_cyc = 0, lat;
  bit hold = 0, pend_rd = 0;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      busy = 0; rdy = 0; pend = 0;
    end else if (pend > 0) begin
      pend--;
      busy = pend > 0;
      rdy = pend == 0 && (pend_rd || $urandom_range(1) == 1);
      rdata = pend_rd ? pend_data : 8'($urandom);
    end else begin
      rdy = 0;
      if (!cs_m) begin
        log_q.push_back('{w: wr_m, a: addr_m, d: wd_m});
        req_cyc = cyc + 1;
        pend_rd = !wr_m;
        if (wr_m) begin mem[addr_m] = wd_m; wr_cnt++; end
        else pend_data = bad.exists(addr_m) ? mem[addr_m] ^ cmask : mem[addr_m];
        lat = wr_m ? wr_lat : rd_lat;
        if (lat == 0) lat = $urandom_range(5, 1);
        pend = (wr_m && hold && wr_cnt == 3) ? 100000 : lat + 1;
      end
    end
  end

  int nchk = 0, npass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) begin npass++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic setup(input bit s, input int wl, input int rl, input bit h);
    sel = s; wr_lat = wl; rd_lat = rl; hold = h; cmask = 8'h00; wr_cnt = 0;
    bad.delete(); log_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0; start_b = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_m && n < 3000) begin @(negedge clk); n++; end
    chk({tag, ".done"}, done_m, 1);
  endtask

  task automatic wait_log(input string tag, input int k);
    int n = 0;
    while (log_q.size() < k && n < 3000) begin @(posedge clk); n++; end
    chk({tag, ".reqseen"}, log_q.size() >= k, 1);
  endtask

  task automatic check_result(input string tag, input logic [23:0] base, input int nlog,
                              input int exp_err, input logic [23:0] exp_ffa, input bit exp_tmo);
    logic [23:0] a;
    chk({tag, ".err"}, err_m, exp_err);
    chk({tag, ".ffa"}, ffa_m, exp_ffa);
    chk({tag, ".tmo"}, tmo_m, exp_tmo);
    chk({tag, ".pass"}, pass_m, exp_err == 0 && !exp_tmo);
    chk({tag, ".led"}, led_m, exp_err == 0 && !exp_tmo);
    chk({tag, ".nreq"}, log_q.size(), nlog);
    for (int i = 0; i < nlog && i < log_q.size(); i++) begin
      a = base + 24'(i % N);
      chk($sformatf("%s.req%0d", tag, i), {log_q[i].w, log_q[i].a, i < N ? log_q[i].d : 8'h00},
          {i < N, a, i < N ? a[7:0] ^ 8'hA5 : 8'h00});
    end
  endtask

  bit rs;
  int ne, k;
  logic [23:0] rbase, rff;
  initial begin
    #1 reset = 0;
    repeat (2) @(negedge clk);
    chk("rst.cs", cs_m, 1);
    chk("rst.outs", {wr_m, done_m, pass_m, tmo_m, led_m, bank_m, wd_m, err_m}, 0);
    chk("rst.addr", {addr_m, ffa_m}, 0);
    reset = 1;
    setup(0, 2, 3, 0);
    pulse_start();
    wait_done("ideal");
    check_result("ideal", 24'h0, 2 * N, 0, 24'h0, 0);
    setup(0, 2, 3, 0);
    bad[24'h2] = 1; cmask = 8'hA7;
    pulse_start();
    wait_done("corrupt");
    check_result("corrupt", 24'h0, 2 * N, 1, 24'h2, 0);
    setup(0, 0, 0, 0);
    pulse_start();
    chk("rerun.cleared", {done_m, pass_m, tmo_m, err_m, ffa_m}, 0);
    wait_log("midstart", 1);
    #2 start_a = 1;
    @(posedge clk) #2 start_a = 0;
    wait_done("midstart");
    check_result("midstart", 24'h0, 2 * N, 0, 24'h0, 0);
    pulse_reset();
    setup(1, 0, 0, 0);
    pulse_start();
    wait_done("wrap");
    check_result("wrap", 24'hFFFFFE, 2 * N, 0, 24'h0, 0);
    pulse_reset();
    setup(0, 0, 0, 1);
    pulse_start();
    wait_done("tmo");
    chk("tmo.lat", (cyc - req_cyc) >= 16 && (cyc - req_cyc) <= 17, 1);
    check_result("tmo", 24'h0, 3, 0, 24'h0, 1);
    pulse_reset();
    setup(0, 0, 0, 0);
    pulse_start();
    wait_log("rstrd", N + 1);
    #2 reset = 0;
    #1 chk("rstrd.cs", cs_m, 1);
    chk("rstrd.done", done_m, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    k = log_q.size();
    repeat (30) @(negedge clk);
    chk("rstrd.nostrobe", log_q.size(), k);
    chk("rstrd.idle", done_m, 0);
    setup(0, 0, 0, 0);
    pulse_start();
    wait_done("rstrd.rerun");
    check_result("rstrd.rerun", 24'h0, 2 * N, 0, 24'h0, 0);
    for (int r = 0; r < 6; r++) begin
      rs = 1'($urandom);
      rbase = rs ? 24'hFFFFFE : 24'h0;
      ne = 0; rff = '0;
      pulse_reset();
      setup(rs, 0, 0, 0);
      cmask = 8'($urandom_range(255, 1));
      for (int i = 0; i < N; i++) if ($urandom_range(2) == 0) begin
        bad[rbase + 24'(i)] = 1;
        if (ne == 0) rff = rbase + 24'(i);
        ne++;
      end
      pulse_start();
      wait_done($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), rbase, 2 * N, ne, rff, 0);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
